// File: rtl/kdf_key_serializer.sv
// -----------------------------------------------------------------------------
// kdf_key_serializer
//
// Captures the 128-bit key produced by the Hirose/PRESENT key-derivation block
// on a genuine 0->1 transition of its end signal and streams it MSB byte first
// over a valid/ready byte interface. The internal key copy is zeroized after
// the last byte is accepted, on flush, and on reset.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous, active-high reset
//   kdf_end     in   level end signal from the KDF (only 0->1 triggers capture)
//   kdf_key     in   derived key, valid while kdf_end is high
//   flush       in   synchronous abort/clear, returns to IDLE
//   dout        out  current key byte (0 outside SEND)
//   dout_valid  out  dout holds a valid beat
//   dout_ready  in   sink accepts the beat when dout_valid & dout_ready
//   dout_last   out  high with the final beat
//   busy        out  high while streaming
//   done        out  high once the full key has been transferred
// -----------------------------------------------------------------------------
module kdf_key_serializer #(
   parameter int KEY_WIDTH  = 128,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  kdf_end,
   input  logic [KEY_WIDTH-1:0]  kdf_key,
   input  logic                  flush,
   output logic [BYTE_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  dout_last,
   output logic                  busy,
   output logic                  done
);

   localparam int NBYTES = KEY_WIDTH / BYTE_WIDTH;
   localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q,     state_d;
   logic [KEY_WIDTH-1:0] shift_reg_q, shift_reg_d;
   logic [CNT_W-1:0]     byte_cnt_q,  byte_cnt_d;
   logic                 kdf_end_q;
   logic                 rise;
   logic                 handshake;

   // kdf_end_q resets to 1 so a level already high at reset release is not a rise.
   assign rise = kdf_end & ~kdf_end_q;

   // State, key copy, byte counter and end-signal history registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shift_reg_q <= {KEY_WIDTH{1'b0}};
         byte_cnt_q  <= {CNT_W{1'b0}};
         kdf_end_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         shift_reg_q <= shift_reg_d;
         byte_cnt_q  <= byte_cnt_d;
         kdf_end_q   <= kdf_end;
      end
   end

   // Next-state logic and beat outputs; flush overrides everything at the end.
   always_comb begin
      state_d     = state_q;
      shift_reg_d = shift_reg_q;
      byte_cnt_d  = byte_cnt_q;
      dout        = {BYTE_WIDTH{1'b0}};
      dout_valid  = 1'b0;
      dout_last   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      handshake   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               shift_reg_d = kdf_key;
               byte_cnt_d  = {CNT_W{1'b0}};
               state_d     = ST_SEND;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_SEND: begin
            dout       = shift_reg_q[KEY_WIDTH-1 -: BYTE_WIDTH];
            dout_valid = 1'b1;
            busy       = 1'b1;
            dout_last  = (byte_cnt_q == LAST_IDX);
            handshake  = dout_ready & ~flush;
            if (handshake) begin
               if (byte_cnt_q == LAST_IDX) begin
                  // Last byte gone: wipe the key copy, counter parks at LAST_IDX.
                  shift_reg_d = {KEY_WIDTH{1'b0}};
                  state_d     = ST_DONE;
               end else begin
                  shift_reg_d = shift_reg_q << BYTE_WIDTH;
                  byte_cnt_d  = byte_cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_DONE;
         end
         default: begin
            shift_reg_d = {KEY_WIDTH{1'b0}};
            byte_cnt_d  = {CNT_W{1'b0}};
            state_d     = ST_IDLE;
         end
      endcase

      // Abort: no beat may be counted in this cycle, nothing of the key stays.
      if (flush) begin
         dout        = {BYTE_WIDTH{1'b0}};
         dout_valid  = 1'b0;
         dout_last   = 1'b0;
         shift_reg_d = {KEY_WIDTH{1'b0}};
         byte_cnt_d  = {CNT_W{1'b0}};
         state_d     = ST_IDLE;
      end else begin
         state_d     = state_d;
      end
   end

endmodule
